// File: rtl/data_router_pkg.sv
// Shared constants for the data router command sequencer: router modes,
// FSM state encodings and command field widths.
package data_router_pkg;
  localparam logic [1:0] RR = 2'b00;
  localparam logic [1:0] BR = 2'b01;
  localparam logic [1:0] RP = 2'b10;
  localparam logic [1:0] NE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_LAST  = 2'd2;

  localparam int COLW  = 28;
  localparam int ROWW  = 2;
  localparam int BANKW = 2;
endpackage

// File: rtl/kernel_pos_cnt.sv
// Kernel window position counter: kc runs fastest, kr advances on kc wrap.
// last flags the final tap of the KSIZE x KSIZE window.
module kernel_pos_cnt #(
  parameter int KSIZE = 3,
  parameter int KW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [KW-1:0] kr,
  output logic [KW-1:0] kc,
  output logic          last
);
  localparam logic [KW-1:0] KMAX = KW'(KSIZE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kr <= '0;
      kc <= '0;
    end else if (clr) begin
      kr <= '0;
      kc <= '0;
    end else if (adv) begin
      if (kc == KMAX) begin
        kc <= '0;
        kr <= (kr == KMAX) ? '0 : kr + 1'b1;
      end else begin
        kc <= kc + 1'b1;
      end
    end
  end

  assign last = (kr == KMAX) && (kc == KMAX);
endmodule

// File: rtl/data_router_seq.sv
// Command initiator for the data router: on each staged block it walks one
// KSIZE x KSIZE depthwise window, one handshaked command per kernel tap.
module data_router_seq
  import data_router_pkg::*;
#(
  parameter int POY    = 3,
  parameter int POX    = 16,
  parameter int BUFW   = 32,
  parameter int BUFH   = 3,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blkend,
  input  logic             pe_ready,
  output logic             cmd_vld,
  output logic [1:0]       rpsel,
  output logic [BANKW-1:0] bank,
  output logic [ROWW-1:0]  row,
  output logic [COLW-1:0]  col,
  output logic             data_vld,
  output logic [7:0]       kpos,
  output logic             busy,
  output logic             pass_done,
  output logic             ovf_err
);
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam logic [COLW-1:0] COL_BASE = COLW'((POX - 1) * STRIDE);

  generate
    if ((POX - 1) * STRIDE + KSIZE - 1 >= BUFW) begin : g_bad_bufw
      $error("data_router_seq: kernel window exceeds buffer width");
    end
    if (KSIZE > BUFH) begin : g_bad_bufh
      $error("data_router_seq: KSIZE exceeds buffer rows");
    end
    if (POY > (1 << BANKW)) begin : g_bad_poy
      $error("data_router_seq: POY exceeds addressable banks");
    end
  endgenerate

  logic [1:0]    state;
  logic          pend;
  logic          accept, clr, last;
  logic [KW-1:0] kr, kc;

  assign cmd_vld = (state == ST_ISSUE);
  assign accept  = cmd_vld && pe_ready;
  // A new window always starts from tap 0, whichever path enters ISSUE.
  assign clr = ((state == ST_IDLE) && (blkend || pend)) || ((state == ST_LAST) && pend);

  kernel_pos_cnt #(.KSIZE(KSIZE), .KW(KW)) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (accept),
    .kr    (kr),
    .kc    (kc),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pend    <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (blkend || pend) state <= ST_ISSUE;
          pend <= 1'b0;
        end
        ST_ISSUE: begin
          if (accept && last) state <= ST_LAST;
          if (blkend) begin
            if (pend) ovf_err <= 1'b1;
            pend <= 1'b1;
          end
        end
        ST_LAST: begin
          state <= pend ? ST_ISSUE : ST_IDLE;
          // Pend is consumed here; a blkend landing now becomes the new pend.
          pend  <= blkend;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_vld <= 1'b0;
      kpos     <= '0;
    end else begin
      data_vld <= accept;
      if (accept) kpos <= 8'(kr) * 8'(KSIZE) + 8'(kc);
    end
  end

  always_comb begin
    rpsel = NE;
    row   = '0;
    col   = '0;
    if (cmd_vld) begin
      row = ROWW'(kr);
      if (kc == '0) begin
        rpsel = RR;
      end else begin
        rpsel = RP;
        col   = COL_BASE + COLW'(kc);
      end
    end
  end

  assign bank      = '0;
  assign busy      = (state != ST_IDLE);
  assign pass_done = (state == ST_LAST);
endmodule
